// File: rtl/mouse_arb_pkg.sv
// mouse_arb_pkg: shared types and default screen constants for the cursor position arbiter.
package mouse_arb_pkg;
    localparam int DEF_HOR_PIXELS = 800;
    localparam int DEF_VER_PIXELS = 600;

    typedef enum logic {DRAW, COMMIT} arb_state_t;
    typedef enum logic {OWN_LOCAL, OWN_REMOTE} owner_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } pos_t;
endpackage

// File: rtl/mouse_pos_slot.sv
// mouse_pos_slot: latest-wins holding register with a pending flag for one position requester.
module mouse_pos_slot
    import mouse_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  logic valid,
    output logic ready,
    input  pos_t pos_in,
    output pos_t pos,
    output logic pend
);
    pos_t pos_q;
    logic pend_q;

    assign ready = load;
    assign pos   = pos_q;
    assign pend  = pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            pend_q <= 1'b0;
        end else if (valid && load) begin
            pos_q  <= pos_in;
            pend_q <= 1'b1;
        end else if (clear) begin
            pend_q <= 1'b0;
        end
    end
endmodule

// File: rtl/mouse_pos_arbiter.sv
// mouse_pos_arbiter: commits one of two cursor positions at each vblank rise, local priority with idle-timeout handover.
// Define MOUSE_ARB_CLAMP_EN to clamp the committed position to the visible area.
module mouse_pos_arbiter
    import mouse_arb_pkg::*;
#(
    parameter int HOR_PIXELS     = DEF_HOR_PIXELS,
    parameter int VER_PIXELS     = DEF_VER_PIXELS,
    parameter int TIMEOUT_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic        req0_valid,
    input  logic [11:0] req0_x,
    input  logic [11:0] req0_y,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [11:0] req1_x,
    input  logic [11:0] req1_y,
    output logic        req1_ready,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        owner,
    output logic        frame_update
);
`ifdef MOUSE_ARB_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif
    localparam logic [11:0] XMAX = 12'(HOR_PIXELS - 1);
    localparam logic [11:0] YMAX = 12'(VER_PIXELS - 1);
    localparam logic [5:0]  TMO  = 6'(TIMEOUT_FRAMES);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    pos_t       pos_q, pos_d, slot0, slot1, sel, cpos;
    logic [5:0] idle_q, idle_d, idle_inc;
    logic       vblnk_q, vblnk_qq, upd_q, upd_d;
    logic       pend0, pend1, commit, take0, take1, accept;

    assign accept = state_q == DRAW;

    mouse_pos_slot u_slot0 (
        .clk(clk), .rst_n(rst_n), .load(accept), .clear(commit),
        .valid(req0_valid), .ready(req0_ready),
        .pos_in('{x: req0_x, y: req0_y}), .pos(slot0), .pend(pend0)
    );

    mouse_pos_slot u_slot1 (
        .clk(clk), .rst_n(rst_n), .load(accept), .clear(commit),
        .valid(req1_valid), .ready(req1_ready),
        .pos_in('{x: req1_x, y: req1_y}), .pos(slot1), .pend(pend1)
    );

    // The counter is compared after counting the current silent frame, so the
    // TIMEOUT_FRAMES-th consecutive frame without a local update hands over.
    always_comb begin
        commit   = state_q == COMMIT;
        state_d  = (!commit && vblnk_q && !vblnk_qq) ? COMMIT : DRAW;
        idle_inc = (idle_q == TMO) ? TMO : idle_q + 6'd1;
        take0    = commit && pend0;
        take1    = commit && !pend0 && pend1 && (idle_inc == TMO || owner_q == OWN_REMOTE);
        idle_d   = take0 ? 6'd0 : commit ? idle_inc : idle_q;
        owner_d  = take0 ? OWN_LOCAL : take1 ? OWN_REMOTE : owner_q;
        sel      = take0 ? slot0 : slot1;
        cpos.x   = (CLAMP_EN && sel.x > XMAX) ? XMAX : sel.x;
        cpos.y   = (CLAMP_EN && sel.y > YMAX) ? YMAX : sel.y;
        upd_d    = take0 || take1;
        pos_d    = upd_d ? cpos : pos_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DRAW;
            owner_q  <= OWN_LOCAL;
            pos_q    <= '0;
            idle_q   <= '0;
            vblnk_q  <= 1'b0;
            vblnk_qq <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            pos_q    <= pos_d;
            idle_q   <= idle_d;
            vblnk_q  <= vblnk;
            vblnk_qq <= vblnk_q;
            upd_q    <= upd_d;
        end
    end

    assign xpos         = pos_q.x;
    assign ypos         = pos_q.y;
    assign owner        = owner_q;
    assign frame_update = upd_q;
endmodule

// File: tb/tb_mouse_pos_arbiter.sv
// tb_mouse_pos_arbiter: directed and randomized frames checked against a frame-level model of the arbiter.
module tb_mouse_pos_arbiter;
`ifdef MOUSE_ARB_CLAMP_EN
    localparam bit CL = 1'b1;
`else
    localparam bit CL = 1'b0;
`endif
    localparam int T = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblnk = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [11:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic        req0_ready, req1_ready, owner, frame_update;
    logic [11:0] xpos, ypos;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    bit          p0 = 0, p1 = 0, mown = 0;
    logic [11:0] p0x = 0, p0y = 0, p1x = 0, p1y = 0, mx = 0, my = 0;
    int          midle = 0;

    mouse_pos_arbiter dut (
        .clk(clk), .rst_n(rst_n), .vblnk(vblnk),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
        .xpos(xpos), .ypos(ypos), .owner(owner), .frame_update(frame_update)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_update === 1'b1) pulses++;

    function automatic logic [11:0] lim(input logic [11:0] v, input int max);
        return (CL && int'(v) > max) ? 12'(max) : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input bit r, input logic [11:0] x, input logic [11:0] y);
        @(negedge clk);
        if (r) begin
            req1_valid = 1; req1_x = x; req1_y = y;
            chk("req1_ready_draw", req1_ready, 1);
        end else begin
            req0_valid = 1; req0_x = x; req0_y = y;
            chk("req0_ready_draw", req0_ready, 1);
        end
        @(posedge clk);
        if (r) begin p1 = 1; p1x = x; p1y = y; end
        else   begin p0 = 1; p0x = x; p0y = y; end
        #1;
        req0_valid = 0;
        req1_valid = 0;
    endtask

    // hold = extra cycles vblnk stays high; 0 means a one-cycle glitch.
    task automatic commit_frame(input int hold, input bit stall, input logic [11:0] sx, input logic [11:0] sy);
        bit eu;
        int base;
        @(negedge clk);
        vblnk = 1;
        base = pulses;
        @(posedge clk);
        if (hold == 0) begin
            @(negedge clk);
            vblnk = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("req0_ready_commit", req0_ready, 0);
        chk("req1_ready_commit", req1_ready, 0);
        eu = 0;
        if (p0) begin
            eu = 1; mx = p0x; my = p0y; mown = 0; midle = 0;
        end else begin
            midle = (midle < T) ? midle + 1 : T;
            if (p1 && (midle == T || mown)) begin
                eu = 1; mx = p1x; my = p1y; mown = 1;
            end
        end
        p0 = 0;
        p1 = 0;
        if (stall) begin
            req0_valid = 1; req0_x = sx; req0_y = sy;
        end
        @(posedge clk);
        @(negedge clk);
        chk("frame_update_pulse", frame_update, eu);
        chk("xpos", xpos, lim(mx, 799));
        chk("ypos", ypos, lim(my, 599));
        chk("owner", owner, mown);
        if (stall) chk("req0_ready_after_commit", req0_ready, 1);
        @(posedge clk);
        if (stall) begin p0 = 1; p0x = sx; p0y = sy; end
        @(negedge clk);
        req0_valid = 0;
        chk("frame_update_clear", frame_update, 0);
        repeat (hold) @(negedge clk);
        vblnk = 0;
        repeat (3) @(negedge clk);
        chk("pulses_per_frame", pulses - base, eu);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_xpos", xpos, 0);
        chk("rst_ypos", ypos, 0);
        chk("rst_owner", owner, 0);
        chk("rst_frame_update", frame_update, 0);
        chk("rst_req0_ready", req0_ready, 1);
        chk("rst_req1_ready", req1_ready, 1);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // local priority
        offer(0, 100, 200);
        offer(1, 300, 400);
        commit_frame(4, 0, 0, 0);

        // handover after TIMEOUT silent frames, then local reclaim
        for (int f = 1; f <= T; f++) begin
            offer(1, 50, 60);
            commit_frame(2, 0, 0, 0);
        end
        chk("handover_owner", owner, 1);
        offer(0, 10, 10);
        commit_frame(2, 0, 0, 0);
        chk("reclaim_owner", owner, 0);
        offer(1, 70, 80);
        commit_frame(2, 0, 0, 0);
        chk("idle_reset_no_handover_x", xpos, lim(10, 799));

        // latest wins, and an offer during COMMIT lands in the next frame
        offer(0, 1, 1);
        offer(0, 2, 2);
        offer(0, 3, 3);
        commit_frame(2, 1, 7, 7);
        commit_frame(2, 0, 0, 0);

        // clamp boundary
        offer(0, 900, 4095);
        commit_frame(2, 0, 0, 0);
        offer(0, 799, 599);
        commit_frame(2, 0, 0, 0);

        // vblnk held high, then an empty frame
        offer(0, 11, 22);
        commit_frame(45, 0, 0, 0);
        commit_frame(2, 0, 0, 0);

        // single-cycle vblnk glitch
        offer(0, 33, 44);
        commit_frame(0, 0, 0, 0);

        // randomized frames
        for (int f = 0; f < 50; f++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++)
                offer($urandom_range(0, 2) != 0, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
            commit_frame($urandom_range(0, 4), $urandom_range(0, 3) == 0,
                         12'($urandom_range(0, 1000)), 12'($urandom_range(0, 700)));
        end

        // reset asserted in the COMMIT cycle
        offer(0, 123, 45);
        commit_frame(2, 0, 0, 0);
        offer(0, 321, 54);
        offer(1, 222, 111);
        @(negedge clk);
        vblnk = 1;
        base = pulses;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_commit_xpos", xpos, 0);
        chk("rst_commit_ypos", ypos, 0);
        chk("rst_commit_owner", owner, 0);
        chk("rst_commit_frame_update", frame_update, 0);
        chk("rst_commit_ready", req0_ready, 1);
        vblnk = 0;
        @(negedge clk);
        rst_n = 1;
        p0 = 0; p1 = 0; mx = 0; my = 0; mown = 0; midle = 0;
        repeat (5) @(negedge clk);
        chk("rst_commit_no_pulse", pulses - base, 0);
        commit_frame(2, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mouse_pos_arbiter.md
# mouse_pos_arbiter

Shares the single cursor datapath (the mouse-draw stage fed with `xpos`/`ypos`) between two position sources: requester 0 is the local mouse controller and requester 1 is the remote or secondary source. Positions are accepted at any time, but they are committed to the draw stage only at the start of vertical blanking, so the cursor never tears mid-frame. The arbiter applies fixed priority with an idle-timeout handover. It sits between the mouse/UART position producers and the draw-mouse stage, in the pixel-clock domain.

## Interface
- `HOR_PIXELS`, 800, visible width; x clamp limit is `HOR_PIXELS-1`.
- `VER_PIXELS`, 600, visible height; y clamp limit is `VER_PIXELS-1`.
- `TIMEOUT_FRAMES`, 60, number of consecutive frames without a req0 update before req1 may own the cursor; range 1..63.
- `clk` in 1: pixel clock; the block has one clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `vblnk` in 1: vertical blank from the timing chain.
- `req0_valid` in 1, `req0_x` in 12, `req0_y` in 12: local position offer.
- `req0_ready` out 1: req0 capture enable.
- `req1_valid` in 1, `req1_x` in 12, `req1_y` in 12: secondary position offer.
- `req1_ready` out 1: req1 capture enable.
- `xpos` out 12, `ypos` out 12: committed cursor position, fed to the draw stage.
- `owner` out 1: requester whose data was last committed.
- `frame_update` out 1: single-cycle pulse when `xpos`/`ypos` are (re)committed.

## Operation
- Each requester has a holding slot with fields `x`, `y` and `pend`.
  - A transfer happens on `valid && ready`.
  - Latest data wins: a new transfer overwrites a slot that is already pending.
- `reqN_ready` is 1 in state DRAW and 0 in state COMMIT.
- The FSM has two states, DRAW and COMMIT; it resets to DRAW.
  - DRAW → COMMIT when `vblnk` is sampled 1 and the registered previous value of `vblnk` is 0 (rising edge).
  - COMMIT → DRAW unconditionally after one cycle.
- Decision taken in the COMMIT cycle, first match wins:
  1. `pend0`: select slot0, `owner`=0, `idle_cnt`=0.
  2. `pend1` and `idle_cnt`==`TIMEOUT_FRAMES`: select slot1, `owner`=1.
  3. `owner`==1 and `pend1`: select slot1.
  4. Otherwise: hold `xpos`/`ypos`; `frame_update` stays 0.
- `idle_cnt` (6 bits) increments on every commit without `pend0` and saturates at `TIMEOUT_FRAMES`.
- Both `pend` flags clear in COMMIT. Data in an unselected slot is discarded.
- A `frame_update` pulse is emitted only when case 1, 2 or 3 applies.
- Clamp (see Configuration): `xpos` = min(x, `HOR_PIXELS-1`), `ypos` = min(y, `VER_PIXELS-1`). The comparison is unsigned 12-bit.

## Timing
- Reset values: `xpos`=0, `ypos`=0, `owner`=0, `frame_update`=0, `reqN_ready`=1, `idle_cnt`=0, both `pend`=0, state DRAW, `vblnk_q`=0.
- Latency:
  - Edge k samples the `vblnk` rise.
  - Edge k+1 enters COMMIT.
  - Edge k+2 registers `xpos`, `ypos`, `owner` and `frame_update`=1, and returns to DRAW.
  - Edge k+3 clears `frame_update`.
- A transfer at edge k (state still DRAW) is included in that frame's commit.
- `valid` during COMMIT is not accepted. The producer must hold its data, per the handshake rule.
- `vblnk` held high does not retrigger; one commit per frame.
- A `vblnk` glitch (high for one cycle) still triggers exactly one commit.
- Asserting `rst_n` low in any state, COMMIT included, forces reset values immediately; pending data is lost.

## Configuration
- `MOUSE_ARB_CLAMP_EN` defined: clamping as described in Operation.
- `MOUSE_ARB_CLAMP_EN` undefined: the raw 12-bit slot values pass to `xpos`/`ypos` unchanged.
- Timing and arbitration are identical in both builds.

## Structure
- Shared package `mouse_arb_pkg`:
  - `arb_state_t` enum {DRAW, COMMIT}
  - `owner_t` enum {OWN_LOCAL, OWN_REMOTE}
  - `pos_t` struct {x[11:0], y[11:0]}
  - default `HOR_PIXELS`/`VER_PIXELS` constants
- One sub-module, `mouse_pos_slot`, instantiated twice. It holds the latest-wins register and the `pend` flag, with `load`, `clear`, `ready`, `valid` and `pos` ports.
- FSM, idle counter, clamp and output registers live in the top level.

## Test plan
- Local priority: after reset, req0 offers (100,200) and req1 offers (300,400) in the same frame → after the `vblnk` rise, `xpos`=100, `ypos`=200, `owner`=0, and one `frame_update` pulse at edge k+2.
- Handover: req0 is silent while req1 offers (50,60) every frame → no `frame_update` for frames 1..59; frame 60 commits (50,60) with `owner`=1. A req0 offer of (10,10) in the next frame → `owner`=0 and `idle_cnt` reset to 0.
- Latest-wins and COMMIT stall: req0 sends (1,1), (2,2), (3,3) in one frame → commit (3,3). A `valid` presented during COMMIT sees `ready`=0 and is accepted on the following cycle, landing in the next frame.
- Clamp: with `MOUSE_ARB_CLAMP_EN`, req0 offers (900,4095) → `xpos`=799, `ypos`=599. Without the macro → 900/4095.
- `vblnk` held high for 3 frames' worth of cycles → exactly one commit. No offers in the following frame → `xpos`/`ypos` hold and `frame_update` stays 0.
- Reset mid-COMMIT: pull `rst_n` low in the COMMIT cycle → outputs go to 0 asynchronously, with no `frame_update` pulse afterwards.
